// File: rtl/mult_unit_if.sv
// mult_unit_if: execute-stage bundle between the control/issue side and the
// iterative multiplier.
//   InValid : instruction valid in execute
//   ALUOp   : ALU operation code (4'b1000 = mult)
//   A, B    : rs / rt operands, two's complement
//   Busy    : multiply in progress
//   Done    : one-cycle pulse, Hi/Lo just updated
//   Stall   : mult presented while Busy
//   Hi, Lo  : upper / lower product halves
// master = issuing pipeline side, slave = multiplier.
interface mult_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             InValid;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             Stall;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output InValid, ALUOp, A, B,
    input  Busy, Done, Stall, Hi, Lo
  );

  modport slave (
    input  InValid, ALUOp, A, B,
    output Busy, Done, Stall, Hi, Lo
  );
endinterface

// File: rtl/mult_unit.sv
// mult_unit: iterative signed WIDTHxWIDTH shift-add multiplier.
// Operates on operand magnitudes for WIDTH cycles, then applies the sign in
// one extra cycle and writes the 2*WIDTH product into Hi/Lo.
// Latency from accepted start to Hi/Lo update is WIDTH+1 cycles.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : mult_unit_if slave modport (operands in, status/product out)
module mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mult_unit_if.slave  bus
);

  localparam int unsigned CW       = $clog2(WIDTH) + 1;
  localparam int unsigned PW       = 2 * WIDTH;
  localparam logic [3:0]  ALU_MULT = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic             r_neg;
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_mult;
  logic             w_busy;
  logic             w_start;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_nxt;
  logic [PW-1:0]    w_result;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign w_is_mult = bus.InValid && (bus.ALUOp == ALU_MULT);
  assign w_busy    = (r_state != S_IDLE);
  assign w_start   = w_is_mult && !w_busy && !reset;
  assign w_last    = (r_count == CW'(WIDTH - 1));

  // Magnitudes: the most negative value negates to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so no overflow handling is needed.
  assign w_abs_a = bus.A[WIDTH-1] ? ('0 - bus.A) : bus.A;
  assign w_abs_b = bus.B[WIDTH-1] ? ('0 - bus.B) : bus.B;

  // --------------------------------------------------------------------------
  // Datapath combinational terms
  // --------------------------------------------------------------------------
  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_addend;
  assign w_result  = r_neg ? ('0 - r_acc) : r_acc;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_SIGN;
        end
      end
      S_SIGN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mcand  <= PW'(w_abs_a);
            r_mplier <= w_abs_b;
            r_neg    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= {r_mcand[PW-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_count  <= r_count + CW'(1);
        end
        S_SIGN: begin
          r_hi   <= w_result[PW-1:WIDTH];
          r_lo   <= w_result[WIDTH-1:0];
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.Busy  = w_busy;
  assign bus.Done  = r_done;
  assign bus.Stall = w_is_mult && w_busy;
  assign bus.Hi    = r_hi;
  assign bus.Lo    = r_lo;

endmodule
